// File: rtl/heater_loop_sequencer_if.sv
// -----------------------------------------------------------------------------
// heater_loop_sequencer_if
//
// Bundles the sensor and PID handshakes around the heater loop sequencer.
//
// Handshake semantics (both directions):
//   sample_req   level request, held high by the sequencer while it waits for
//                a sample; the sensor answers with a one-cycle sample_ack and
//                sample_data is only meaningful in that ack cycle.
//   pid_start    one-cycle pulse; the PID block answers with a one-cycle
//                pid_computed and pid_response is only meaningful in that cycle.
//   Acks/results arriving while the sequencer is not waiting for them are
//   dropped.
//
// Signals
//   sample_req      sequencer -> sensor   request a temperature sample
//   sample_ack      sensor -> sequencer   sample_data valid this cycle
//   sample_data     sensor -> sequencer   unsigned Q7.4 temperature
//   measured_value  sequencer -> PID      held sample
//   pid_start       sequencer -> PID      start one computation
//   pid_computed    PID -> sequencer      pid_response valid this cycle
//   pid_response    PID -> sequencer      signed Q7.4 controller output
//
// Modports: master = sequencer side, slave = sensor/PID side.
// -----------------------------------------------------------------------------
interface heater_loop_sequencer_if #(
    parameter int WIDTH = 12
);
    logic             sample_req;
    logic             sample_ack;
    logic [WIDTH-1:0] sample_data;
    logic [WIDTH-1:0] measured_value;
    logic             pid_start;
    logic             pid_computed;
    logic [WIDTH-1:0] pid_response;

    modport master (
        output sample_req,
        input  sample_ack,
        input  sample_data,
        output measured_value,
        output pid_start,
        input  pid_computed,
        input  pid_response
    );

    modport slave (
        input  sample_req,
        output sample_ack,
        output sample_data,
        input  measured_value,
        input  pid_start,
        output pid_computed,
        output pid_response
    );
endinterface

// File: rtl/heater_loop_sequencer.sv
// -----------------------------------------------------------------------------
// heater_loop_sequencer
//
// Runs one closed-loop heater control iteration every PERIOD clocks:
// request a temperature sample, start the PID, wait for its result and turn
// it into a PWM duty on the heater drive. Duty changes only at a PWM frame
// boundary so every frame is complete. Sensor and PID responses are
// supervised by timeouts; a timeout parks the loop in FAULT (heater off)
// until reset.
//
// Ports
//   CLK         clock, rising edge
//   RST         synchronous active-high reset
//   enable      loop enable; low forces heater off and the loop idle
//   bus         heater_loop_sequencer_if.master (sensor + PID handshakes)
//   heater_pwm  heater drive, high = on
//   duty        duty currently applied, 0..63 of a 64-cycle frame
//   busy        an iteration is in progress (REQ/START/WAIT)
//   overrun     sticky: a period tick arrived while busy
//   fault       sticky: sensor or PID timeout
//   state_dbg   current FSM state encoding (IDLE=0 REQ=1 START=2 WAIT=3 FAULT=4)
// -----------------------------------------------------------------------------
module heater_loop_sequencer #(
    parameter int WIDTH          = 12,
    parameter int PERIOD         = 1000,
    parameter int SENSOR_TIMEOUT = 64,
    parameter int PID_TIMEOUT    = 16
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          enable,
    heater_loop_sequencer_if.master       bus,
    output logic                          heater_pwm,
    output logic [5:0]                    duty,
    output logic                          busy,
    output logic                          overrun,
    output logic                          fault,
    output logic [2:0]                    state_dbg
);

    // ------------------------------------------------------------------
    // Local sizing
    // ------------------------------------------------------------------
    localparam int PW      = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int TMO_MAX = (SENSOR_TIMEOUT > PID_TIMEOUT) ? SENSOR_TIMEOUT : PID_TIMEOUT;
    localparam int TW      = (TMO_MAX > 1) ? $clog2(TMO_MAX) : 1;
    localparam int IW      = WIDTH - 5;   // integer bits of Q7.4 (sign and fraction removed)

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        FAULT = 3'd4
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [PW-1:0]    period_cnt;
    logic             tick;
    logic [TW-1:0]    tmo_cnt;
    logic [5:0]       frame_cnt;
    logic [5:0]       shadow_q;
    logic [5:0]       duty_q;
    logic [5:0]       duty_new;
    logic [WIDTH-1:0] measured_q;
    logic             overrun_q;
    logic             in_busy;
    logic             accept_sample;
    logic             accept_pid;
    logic             sensor_expired;
    logic             pid_expired;
    logic [IW-1:0]    resp_int;
    logic             unused_frac;

    // ------------------------------------------------------------------
    // Period tick: free-running, independent of state and enable
    // ------------------------------------------------------------------
    assign tick = (period_cnt == PW'(PERIOD - 1));

    // ------------------------------------------------------------------
    // Qualified handshake events
    // ------------------------------------------------------------------
    assign in_busy       = (state_q == REQ) || (state_q == START) || (state_q == WAIT);
    assign accept_sample = (state_q == REQ)  && enable && bus.sample_ack;
    assign accept_pid    = (state_q == WAIT) && enable && bus.pid_computed;

    // tmo_cnt is 0 in the first cycle of a state, so the limit is reached
    // in the N-th cycle spent waiting and FAULT follows one cycle later.
    assign sensor_expired = (tmo_cnt == TW'(SENSOR_TIMEOUT - 1));
    assign pid_expired    = (tmo_cnt == TW'(PID_TIMEOUT - 1));

    // ------------------------------------------------------------------
    // PID response to duty: negative -> 0, integer part saturated to 63,
    // fraction truncated.
    // ------------------------------------------------------------------
    assign resp_int    = bus.pid_response[WIDTH-2:4];
    assign unused_frac = ^bus.pid_response[3:0];

    always_comb begin
        duty_new = 6'd0;
        if (bus.pid_response[WIDTH-1]) begin
            duty_new = 6'd0;
        end else if (resp_int > IW'(63)) begin
            duty_new = 6'd63;
        end else begin
            duty_new = resp_int[5:0];
        end
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (tick && enable) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (bus.sample_ack) begin
                    state_d = START;
                end else if (sensor_expired) begin
                    state_d = FAULT;
                end
            end
            START: begin
                if (!enable) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (bus.pid_computed) begin
                    state_d = IDLE;
                end else if (pid_expired) begin
                    state_d = FAULT;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            period_cnt <= '0;
            tmo_cnt    <= '0;
            frame_cnt  <= '0;
            shadow_q   <= '0;
            duty_q     <= '0;
            measured_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q <= state_d;

            if (tick) begin
                period_cnt <= '0;
            end else begin
                period_cnt <= period_cnt + 1'b1;
            end

            frame_cnt <= frame_cnt + 1'b1;

            // Timeout counter restarts on every state entry.
            if (state_d != state_q) begin
                tmo_cnt <= '0;
            end else if ((state_q == REQ) || (state_q == WAIT)) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end

            if (accept_sample) begin
                measured_q <= bus.sample_data;
            end

            // A tick that lands while an iteration is still running is
            // dropped and flagged; ticks in FAULT are not flagged.
            if (tick && in_busy) begin
                overrun_q <= 1'b1;
            end

            // Disable and fault both force the heater to zero duty.
            if (!enable || (state_q == FAULT) || (state_d == FAULT)) begin
                shadow_q <= '0;
                duty_q   <= '0;
            end else begin
                if (accept_pid) begin
                    shadow_q <= duty_new;
                end
                // Shadow moves to the live duty only at the 63 -> 0 wrap so
                // the new value governs a whole frame from its first cycle.
                if (frame_cnt == 6'd63) begin
                    duty_q <= shadow_q;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.sample_req     = (state_q == REQ);
    assign bus.pid_start      = (state_q == START);
    assign bus.measured_value = measured_q;

    assign fault      = (state_q == FAULT);
    assign busy       = in_busy;
    assign overrun    = overrun_q;
    assign duty       = duty_q;
    assign heater_pwm = enable && (state_q != FAULT) && (frame_cnt < duty_q);
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_heater_loop_sequencer.sv
// -----------------------------------------------------------------------------
// tb_heater_loop_sequencer
//
// Directed bench for heater_loop_sequencer. The bench keeps its own cycle
// count since reset; period phase = cyc % PERIOD and PWM frame = cyc % 64.
// A second instance with a 20-cycle period and a slow sensor covers overrun.
// -----------------------------------------------------------------------------
module tb_heater_loop_sequencer;

    localparam int WIDTH = 12;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic RST2 = 1'b1;
    logic enable = 1'b1;
    logic enable2 = 1'b0;

    always #5 CLK = ~CLK;

    heater_loop_sequencer_if #(.WIDTH(WIDTH)) bus ();
    heater_loop_sequencer_if #(.WIDTH(WIDTH)) bus2 ();

    logic       heater_pwm, busy, overrun, fault;
    logic [5:0] duty;
    logic [2:0] state_dbg;
    logic       heater_pwm2, busy2, overrun2, fault2;
    logic [5:0] duty2;
    logic [2:0] state_dbg2;

    heater_loop_sequencer #(
        .WIDTH(WIDTH), .PERIOD(1000), .SENSOR_TIMEOUT(64), .PID_TIMEOUT(16)
    ) dut (
        .CLK(CLK), .RST(RST), .enable(enable), .bus(bus.master),
        .heater_pwm(heater_pwm), .duty(duty), .busy(busy),
        .overrun(overrun), .fault(fault), .state_dbg(state_dbg)
    );

    heater_loop_sequencer #(
        .WIDTH(WIDTH), .PERIOD(20), .SENSOR_TIMEOUT(64), .PID_TIMEOUT(16)
    ) dut_ovr (
        .CLK(CLK), .RST(RST2), .enable(enable2), .bus(bus2.master),
        .heater_pwm(heater_pwm2), .duty(duty2), .busy(busy2),
        .overrun(overrun2), .fault(fault2), .state_dbg(state_dbg2)
    );

    // ---------------- scoreboard counters ----------------
    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
        cyc = 0;
    endtask

    // Wait (bounded) for sample_req; returns number of cycles waited.
    task automatic wait_req(output int n);
        n = 0;
        while (bus.sample_req !== 1'b1 && n < 1100) begin
            step();
            n++;
        end
        chk("req_seen", {31'd0, bus.sample_req}, 32'd1);
    endtask

    // Step to the next frame start, checking heater_pwm against duty d on
    // every cycle visited (from the current frame position to 63).
    task automatic run_to_wrap(input string tag, input int d);
        int bad;
        int f;
        bad = 0;
        do begin
            f = cyc % 64;
            if (heater_pwm !== ((f < d) ? 1'b1 : 1'b0)) bad++;
            step();
        end while ((cyc % 64) != 0);
        chk(tag, bad, 0);
    endtask

    // One full iteration. align=1 places pid_computed at frame 20.
    task automatic do_iter(input string tag, input logic [11:0] data, input logic [11:0] resp,
                           input int exp_duty, input int prev_duty, input bit align,
                           input int ack_dly, input int pid_dly);
        int n;
        int a;
        wait_req(n);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        a = align ? ((16 - (cyc % 64) + 64) % 64) : ack_dly;
        repeat (a) step();
        bus.sample_ack  = 1'b1;
        bus.sample_data = data;
        step();
        bus.sample_ack  = 1'b0;
        bus.sample_data = 12'hABC;
        chk({tag, "_meas"}, {20'd0, bus.measured_value}, {20'd0, data});
        chk({tag, "_start"}, {31'd0, bus.pid_start}, 32'd1);
        chk({tag, "_req_low"}, {31'd0, bus.sample_req}, 32'd0);
        step();
        chk({tag, "_start_1cyc"}, {31'd0, bus.pid_start}, 32'd0);
        repeat ((align ? 3 : pid_dly) - 1) step();
        if (align) chk({tag, "_frame20"}, cyc % 64, 20);
        bus.pid_computed = 1'b1;
        bus.pid_response = resp;
        step();
        bus.pid_computed = 1'b0;
        bus.pid_response = 12'h000;
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
        chk({tag, "_duty_held"}, {26'd0, duty}, prev_duty);
        run_to_wrap({tag, "_old_frame"}, prev_duty);
        chk({tag, "_duty"}, {26'd0, duty}, exp_duty);
        run_to_wrap({tag, "_new_frame"}, exp_duty);
        chk({tag, "_meas_hold"}, {20'd0, bus.measured_value}, {20'd0, data});
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int hits;
        bus.sample_ack    = 1'b0;
        bus.sample_data   = '0;
        bus.pid_computed  = 1'b0;
        bus.pid_response  = '0;
        bus2.sample_ack   = 1'b0;
        bus2.sample_data  = '0;
        bus2.pid_computed = 1'b0;
        bus2.pid_response = '0;

        // Reset state
        do_reset();
        chk("rst_state", {29'd0, state_dbg}, 32'd0);
        chk("rst_req", {31'd0, bus.sample_req}, 32'd0);
        chk("rst_start", {31'd0, bus.pid_start}, 32'd0);
        chk("rst_meas", {20'd0, bus.measured_value}, 32'd0);
        chk("rst_duty", {26'd0, duty}, 32'd0);
        chk("rst_pwm", {31'd0, heater_pwm}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_flags", {30'd0, overrun, fault}, 32'd0);

        // First tick at count 999 -> sample_req at cycle 1000
        wait_req(n);
        chk("first_tick_latency", n, 1000);

        // Nominal: ack 3 cycles after req, PID 5 cycles after start
        do_iter("nom", 12'h190, 12'h200, 32, 0, 1'b0, 3, 5);
        // Frame alignment with saturation of a large response
        do_iter("sat7f0", 12'h1A0, 12'h7F0, 63, 32, 1'b1, 0, 0);
        do_iter("sat3f8", 12'h1B0, 12'h3F8, 63, 63, 1'b0, 2, 3);
        do_iter("neg80f", 12'h1C0, 12'h80F, 0, 63, 1'b0, 5, 7);
        do_iter("frac01f", 12'h1D0, 12'h01F, 1, 0, 1'b1, 0, 0);

        // Stray ack / computed in IDLE are ignored
        bus.sample_ack = 1'b1;  bus.sample_data = 12'h555;
        bus.pid_computed = 1'b1; bus.pid_response = 12'h200;
        step();
        bus.sample_ack = 1'b0;  bus.pid_computed = 1'b0;
        chk("idle_ack_ignored", {20'd0, bus.measured_value}, 32'h1D0);
        chk("idle_stay", {29'd0, state_dbg}, 32'd0);
        run_to_wrap("idle_pid_ignored_a", 1);
        chk("idle_pid_ignored", {26'd0, duty}, 32'd1);

        // Enable drop during WAIT
        wait_req(n);
        bus.sample_ack = 1'b1; bus.sample_data = 12'h1E0;
        step();
        bus.sample_ack = 1'b0;
        step();
        chk("en_in_wait", {29'd0, state_dbg}, 32'd3);
        enable = 1'b0;
        #1;
        chk("en_pwm_off", {31'd0, heater_pwm}, 32'd0);
        step();
        chk("en_idle", {29'd0, state_dbg}, 32'd0);
        chk("en_duty0", {26'd0, duty}, 32'd0);
        chk("en_req0", {31'd0, bus.sample_req}, 32'd0);
        chk("en_meas_hold", {20'd0, bus.measured_value}, 32'h1E0);
        repeat (10) step();
        enable = 1'b1;
        wait_req(n);
        chk("reenable_on_tick", cyc % 1000, 0);
        chk("no_overrun", {31'd0, overrun}, 32'd0);

        // PID timeout: ack now, never compute
        bus.sample_ack = 1'b1; bus.sample_data = 12'h1F0;
        step();
        bus.sample_ack = 1'b0;
        repeat (16) step();
        chk("pid_tmo_edge", {31'd0, fault}, 32'd0);
        step();
        chk("pid_tmo_fault", {31'd0, fault}, 32'd1);
        chk("pid_tmo_busy", {31'd0, busy}, 32'd0);
        bus.pid_computed = 1'b1; bus.pid_response = 12'h200;
        step();
        bus.pid_computed = 1'b0;
        run_to_wrap("pid_tmo_pwm_a", 0);
        run_to_wrap("pid_tmo_pwm_b", 0);
        chk("pid_late_ignored", {26'd0, duty}, 32'd0);
        chk("pid_tmo_sticky", {31'd0, fault}, 32'd1);

        // Reset clears the fault
        do_reset();
        chk("rst2_fault", {31'd0, fault}, 32'd0);
        chk("rst2_meas", {20'd0, bus.measured_value}, 32'd0);
        chk("rst2_state", {29'd0, state_dbg}, 32'd0);

        // Sensor timeout: never ack
        wait_req(n);
        chk("tick_after_rst", n, 1000);
        repeat (63) step();
        chk("sens_tmo_edge", {30'd0, bus.sample_req, fault}, 32'd2);
        step();
        chk("sens_tmo_fault", {31'd0, fault}, 32'd1);
        chk("sens_tmo_req", {31'd0, bus.sample_req}, 32'd0);
        chk("sens_tmo_state", {29'd0, state_dbg}, 32'd4);
        hits = 0;
        repeat (1100) begin
            if (bus.sample_req === 1'b1 || heater_pwm === 1'b1) hits++;
            step();
        end
        chk("fault_ticks_ignored", hits, 0);
        chk("fault_no_overrun", {31'd0, overrun}, 32'd0);
        chk("fault_duty", {26'd0, duty}, 32'd0);
        do_reset();
        chk("rst3_clear", {30'd0, overrun, fault}, 32'd0);

        // Overrun: 20-cycle period, sensor slower than one period
        RST2 = 1'b1;
        step();
        RST2 = 1'b0;
        repeat (45) step();
        chk("ovr_disabled_idle", {30'd0, busy2, overrun2}, 32'd0);
        enable2 = 1'b1;
        n = 0;
        while (bus2.sample_req !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        chk("ovr_req", {31'd0, bus2.sample_req}, 32'd1);
        chk("ovr_before", {31'd0, overrun2}, 32'd0);
        repeat (25) step();
        chk("ovr_set", {31'd0, overrun2}, 32'd1);
        bus2.sample_ack = 1'b1; bus2.sample_data = 12'h0AB;
        step();
        bus2.sample_ack = 1'b0;
        chk("ovr_meas", {20'd0, bus2.measured_value}, 32'h0AB);
        step();
        bus2.pid_computed = 1'b1; bus2.pid_response = 12'h100;
        step();
        bus2.pid_computed = 1'b0;
        chk("ovr_done", {31'd0, busy2}, 32'd0);
        chk("ovr_sticky", {31'd0, overrun2}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/heater_loop_sequencer.md
# heater_loop_sequencer

Sequences one closed-loop control iteration of the water heater at a fixed sample rate. Each iteration requests a temperature sample, hands it to the PID datapath, waits for the PID result, and converts it into a glitch-free PWM duty on the heater drive output. It sits between the temperature sensor interface, the PID block and the heater driver. It also owns sensor and PID timeout supervision.

## Interface
- WIDTH, 12: sample/response width; Q7.4 signed (bit 11 sign, [10:4] integer, [3:0] fraction)
- PERIOD, 1000: clock cycles between control iterations (≥ 2·PWM frame)
- SENSOR_TIMEOUT, 64: max cycles from sample_req rise to sample_ack
- PID_TIMEOUT, 16: max cycles from pid_start to pid_computed
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- enable  in  1  loop enable; low forces heater off and idle
- sample_req  out  1  request to sensor interface
- sample_ack  in  1  one-cycle pulse; sample_data valid this cycle
- sample_data  in  WIDTH  measured temperature (unsigned Q7.4)
- measured_value  out  WIDTH  held sample presented to PID
- pid_start  out  1  one-cycle pulse starting one PID computation
- pid_computed  in  1  one-cycle pulse; pid_response valid this cycle
- pid_response  in  WIDTH  signed Q7.4 PID output
- heater_pwm  out  1  heater drive, high = on
- duty  out  6  duty currently applied, 0..63 of a 64-cycle frame
- busy  out  1  high in any state other than IDLE/FAULT
- overrun  out  1  sticky: tick arrived while busy
- fault  out  1  sticky: sensor or PID timeout

## Operation
- Reset values: all outputs 0; state IDLE; period, PWM and timeout counters 0; shadow duty 0.
- Period counter: counts 0..PERIOD-1 and wraps; tick = (count == PERIOD-1). Runs regardless of state and enable.
- States:
  - IDLE: on tick with enable=1, go to REQ.
  - REQ: sample_req=1. On sample_ack, latch sample_data into measured_value, drop sample_req next cycle, go to START. At SENSOR_TIMEOUT cycles without ack, go to FAULT.
  - START: pid_start=1 for exactly one cycle, go to WAIT.
  - WAIT: on pid_computed, compute new duty into shadow, go to IDLE. At PID_TIMEOUT cycles without computed, go to FAULT.
  - FAULT: heater_pwm=0, duty=0, fault=1. Leaves only on RST.
- Duty conversion: if pid_response[11]=1, duty=0. Otherwise duty=pid_response[10:4], saturated to 63. The fraction bits are discarded (truncation).
- PWM: 6-bit frame counter 0..63 free-running. heater_pwm = enable & !fault & (frame_count < duty).
- Duty update rule: the shadow duty transfers to duty only when frame_count wraps 63→0, so there are never partial frames.
- enable=0: any state except FAULT returns to IDLE next cycle, sample_req drops, and duty and shadow clear to 0. measured_value holds.
- Tick while busy or in FAULT: tick is ignored and overrun set (in FAULT, overrun is not set). A tick in the same cycle as the transition to IDLE is ignored and sets overrun.
- sample_ack or pid_computed outside REQ/WAIT: ignored.
- measured_value changes only on an accepted sample_ack.

## Timing
- tick → sample_req high: 1 cycle (registered).
- sample_ack at cycle N → measured_value valid N+1, pid_start high N+1, sample_req low N+1.
- pid_computed at cycle M → shadow updated M+1, busy low M+1.
- Shadow → duty at the next frame wrap, worst case 64 cycles later; heater_pwm reflects the new duty in the first cycle of the frame.
- Timeouts: fault asserts the cycle after the counter reaches its limit. Timeout counters clear on each state entry.
- RST mid-iteration: all state returns to reset values next cycle, including sticky flags.

## Test plan
- Nominal: PERIOD=1000, ack 3 cycles after req with data 0x190 (25.0), PID returns 0x200 (32.0) 5 cycles after start → duty=32 from next frame; heater_pwm high 32 of 64 cycles.
- Saturation/sign: responses 0x7F0 → duty 63; 0x3F8 (63.5) → 63; 0x80F (negative) → 0; 0x01F (1.9375) → 1.
- Frame alignment: pid_computed mid-frame (frame_count=20) → duty unchanged until frame_count 0; no shortened pulse.
- Sensor timeout: no ack for 64 cycles → fault=1, heater_pwm=0, later ticks ignored; RST clears everything.
- PID timeout: ack given, no pid_computed for 16 cycles → fault=1. A pid_computed arriving later is ignored.
- enable deassert during WAIT → IDLE, duty 0, heater off. Re-enable → next tick starts REQ. PERIOD=20 with a slow sensor → overrun sets.
